pad_scanner: RTL and testbench

Drives the DB-9 select line of the SEGA Genesis pad and consumes the 11-bit half-word that the `controller` decoder produces for each select phase. It merges the select-low half (Up, Down, Left, Right, A, Start) and the select-high half (Z, Y, X, B, C) into one button word. The word is debounced across whole scans, and per-button press pulses are generated for the robot command logic. It sits between the pad decoder and the top-level motion/cleaning control.

---
 rtl/pad_pkg.sv | 34 +++
 rtl/pad_debounce.sv | 89 ++++++++
 rtl/pad_scanner.sv | 97 +++++++++
 tb/tb_pad_scanner.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pad_pkg.sv
// Shared types and constants for the Genesis pad scanner.
// Button indices follow the decoder bit order used on buttons_in.
package pad_pkg;

  localparam int NUM_BUTTONS = 11;
  localparam int LO_BITS     = 6;
  localparam int HI_BITS     = 5;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_A     = 4;
  localparam int BTN_START = 5;
  localparam int BTN_Z     = 6;
  localparam int BTN_Y     = 7;
  localparam int BTN_X     = 8;
  localparam int BTN_B     = 9;
  localparam int BTN_C     = 10;

  typedef enum logic [2:0] {
    S_LO_WAIT,
    S_LO_CAP,
    S_HI_WAIT,
    S_HI_CAP,
    S_COMMIT
  } state_t;

  // Counter width that stays legal (>=1) for tiny parameter values.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pad_debounce.sv
// Whole-word debouncer: a scan must repeat DEBOUNCE_SCANS times before it reaches buttons.
// With PAD_SCANNER_RELEASE_EN defined, a release_pulse output is also produced.
module pad_debounce
  import pad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   commit,
  input  logic [NUM_BUTTONS-1:0] scan,
  output logic [NUM_BUTTONS-1:0] buttons,
  output logic [NUM_BUTTONS-1:0] press_pulse,
  output logic                   scan_valid
`ifdef PAD_SCANNER_RELEASE_EN
  ,
  output logic [NUM_BUTTONS-1:0] release_pulse
`endif
);

  localparam int CNT_W = cnt_width(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);

  logic [NUM_BUTTONS-1:0] prev_q, prev_d;
  logic [NUM_BUTTONS-1:0] buttons_q, buttons_d;
  logic [NUM_BUTTONS-1:0] press_q, press_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   valid_q, valid_d;
`ifdef PAD_SCANNER_RELEASE_EN
  logic [NUM_BUTTONS-1:0] release_q, release_d;
`endif

  always_comb begin
    prev_d    = prev_q;
    buttons_d = buttons_q;
    cnt_d     = cnt_q;
    press_d   = '0;
    valid_d   = commit;
`ifdef PAD_SCANNER_RELEASE_EN
    release_d = '0;
`endif
    if (commit) begin
      // Saturate so a long-held word never wraps back into a fresh count.
      if (scan == prev_q) begin
        cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
      end else begin
        cnt_d = CNT_W'(1);
      end
      prev_d = scan;
      if (cnt_d == CNT_MAX) begin
        buttons_d = scan;
        press_d   = scan & ~buttons_q;
`ifdef PAD_SCANNER_RELEASE_EN
        release_d = ~scan & buttons_q;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q    <= '0;
      buttons_q <= '0;
      press_q   <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
`ifdef PAD_SCANNER_RELEASE_EN
      release_q <= '0;
`endif
    end else begin
      prev_q    <= prev_d;
      buttons_q <= buttons_d;
      press_q   <= press_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
`ifdef PAD_SCANNER_RELEASE_EN
      release_q <= release_d;
`endif
    end
  end

  assign buttons     = buttons_q;
  assign press_pulse = press_q;
  assign scan_valid  = valid_q;
`ifdef PAD_SCANNER_RELEASE_EN
  assign release_pulse = release_q;
`endif

endmodule

// File: rtl/pad_scanner.sv
// Genesis pad scanner: drives select, captures both half-words, feeds the debouncer.
// Optional release_pulse output is enabled by defining PAD_SCANNER_RELEASE_EN.
//
// state     | meaning
// S_LO_WAIT | select low, waiting SETTLE_CYCLES for the decoder
// S_LO_CAP  | select low, latch Up/Down/Left/Right/A/Start
// S_HI_WAIT | select high, waiting SETTLE_CYCLES for the decoder
// S_HI_CAP  | select high, latch Z/Y/X/B/C
// S_COMMIT  | select low, hand the full scan to the debouncer
module pad_scanner
  import pad_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 16,
  parameter int DEBOUNCE_SCANS = 3,
  parameter bit ACTIVE_LOW     = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] buttons_in,
  output logic                   select_out,
  output logic [NUM_BUTTONS-1:0] buttons,
  output logic [NUM_BUTTONS-1:0] press_pulse,
  output logic                   scan_valid
`ifdef PAD_SCANNER_RELEASE_EN
  ,
  output logic [NUM_BUTTONS-1:0] release_pulse
`endif
);

  localparam int SETTLE_W = cnt_width(SETTLE_CYCLES);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  state_t               state_q, state_d;
  logic [SETTLE_W-1:0]  settle_q, settle_d;
  logic                 select_q, select_d;
  logic [LO_BITS-1:0]   lo_q, lo_d;
  logic [HI_BITS-1:0]   hi_q, hi_d;

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    case (state_q)
      S_LO_WAIT: if (settle_q == SETTLE_LAST) state_d = S_LO_CAP;
      S_LO_CAP: begin
        lo_d    = buttons_in[BTN_START:BTN_UP] ^ {LO_BITS{ACTIVE_LOW}};
        state_d = S_HI_WAIT;
      end
      S_HI_WAIT: if (settle_q == SETTLE_LAST) state_d = S_HI_CAP;
      S_HI_CAP: begin
        hi_d    = buttons_in[BTN_C:BTN_Z] ^ {HI_BITS{ACTIVE_LOW}};
        state_d = S_COMMIT;
      end
      S_COMMIT: state_d = S_LO_WAIT;
      default:  state_d = S_LO_WAIT;
    endcase

    settle_d = (state_d != state_q) ? '0 : settle_q + SETTLE_W'(1);
    // Select follows the next state so the pin is a clean flop output.
    select_d = (state_d == S_HI_WAIT) || (state_d == S_HI_CAP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_LO_WAIT;
      settle_q <= '0;
      select_q <= 1'b0;
      lo_q     <= '0;
      hi_q     <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      select_q <= select_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
    end
  end

  assign select_out = select_q;

  pad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk          (clk),
    .reset        (reset),
    .commit       (state_q == S_COMMIT),
    .scan         ({hi_q, lo_q}),
    .buttons      (buttons),
    .press_pulse  (press_pulse),
    .scan_valid   (scan_valid)
`ifdef PAD_SCANNER_RELEASE_EN
    ,
    .release_pulse(release_pulse)
`endif
  );

endmodule

// File: tb/tb_pad_scanner.sv
// Bench for pad_scanner: emulated pad/decoder plus a scan-history reference model.
// Checks every cycle; define PAD_SCANNER_RELEASE_EN to also check release_pulse.
module tb_pad_scanner;
  import pad_pkg::*;

  localparam int S = 4;
  localparam int N = 3;
  localparam int P = 2 * S + 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [10:0] buttons_in = 11'h7FF;
  logic        select_out;
  logic [10:0] buttons;
  logic [10:0] press_pulse;
  logic        scan_valid;
`ifdef PAD_SCANNER_RELEASE_EN
  logic [10:0] release_pulse;
  logic [10:0] exp_release, pend_release;
`endif

  always #5 clk = ~clk;

  pad_scanner #(
    .SETTLE_CYCLES (S),
    .DEBOUNCE_SCANS(N),
    .ACTIVE_LOW    (1'b1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .buttons_in   (buttons_in),
    .select_out   (select_out),
    .buttons      (buttons),
    .press_pulse  (press_pulse),
    .scan_valid   (scan_valid)
`ifdef PAD_SCANNER_RELEASE_EN
    ,
    .release_pulse(release_pulse)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int press_seen = 0;

  logic [5:0]  pad_lo = '0;   // logical pressed state of the select-low buttons
  logic [4:0]  pad_hi = '0;   // logical pressed state of the select-high buttons
  logic [10:0] cap = '0;
  logic [10:0] hist[$];
  logic [10:0] exp_buttons = '0, exp_press = '0, pend_buttons = '0, pend_press = '0;
  logic        exp_sel = 1'b0, exp_valid = 1'b0, pend_valid = 1'b0;

  task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed=%h expected=%h", tag, cyc, obs, expv);
    end
  endtask

  task automatic check_outputs();
    check("select_out", {10'b0, select_out}, {10'b0, exp_sel});
    check("scan_valid", {10'b0, scan_valid}, {10'b0, exp_valid});
    check("buttons", buttons, exp_buttons);
    check("press_pulse", press_pulse, exp_press);
`ifdef PAD_SCANNER_RELEASE_EN
    check("release_pulse", release_pulse, exp_release);
`endif
  endtask

  // Decoder emulation: active-low pins, unused half idles high.
  task automatic drive_pad();
    buttons_in = select_out ? {~pad_hi, 6'h3F} : {5'h1F, ~pad_lo};
  endtask

  // A word reaches buttons once the last N scans since reset are identical.
  task automatic commit_model();
    logic [10:0] scan;
    bit stable;
    scan = cap;
    hist.push_back(scan);
    if (hist.size() > N) void'(hist.pop_front());
    stable = (hist.size() == N);
    foreach (hist[i]) if (hist[i] != scan) stable = 0;
    pend_valid = 1'b1;
    if (stable) begin
      pend_buttons = scan;
      pend_press   = scan & ~exp_buttons;
`ifdef PAD_SCANNER_RELEASE_EN
      pend_release = ~scan & exp_buttons;
`endif
    end else begin
      pend_buttons = exp_buttons;
      pend_press   = '0;
`ifdef PAD_SCANNER_RELEASE_EN
      pend_release = '0;
`endif
    end
  endtask

  task automatic step();
    int p;
    @(posedge clk);
    #1;
    cyc++;
    p = cyc % P;
    exp_sel = (p >= S + 1) && (p <= 2 * S + 1);
    if (p == 0 && pend_valid) begin
      exp_valid   = 1'b1;
      exp_buttons = pend_buttons;
      exp_press   = pend_press;
`ifdef PAD_SCANNER_RELEASE_EN
      exp_release = pend_release;
`endif
    end else begin
      exp_valid = 1'b0;
      exp_press = '0;
`ifdef PAD_SCANNER_RELEASE_EN
      exp_release = '0;
`endif
    end
    pend_valid = 1'b0;
    check_outputs();
    if (press_pulse != '0) press_seen++;
    if (p == S) cap[5:0] = pad_lo;
    if (p == 2 * S + 1) cap[10:6] = pad_hi;
    if (p == 2 * S + 2) commit_model();
    @(negedge clk);
    drive_pad();
  endtask

  task automatic run_scans(input int n);
    repeat (n * P) step();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_select", {10'b0, select_out}, 11'h000);
    check("rst_buttons", buttons, 11'h000);
    check("rst_press", press_pulse, 11'h000);
    check("rst_valid", {10'b0, scan_valid}, 11'h000);
    hist.delete();
    cap = '0;
    exp_buttons = '0;
    exp_press = '0;
    exp_valid = 1'b0;
    exp_sel = 1'b0;
    pend_valid = 1'b0;
`ifdef PAD_SCANNER_RELEASE_EN
    exp_release = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_select", {10'b0, select_out}, 11'h000);
    @(negedge clk);
    reset = 1'b1;
    cyc = 0;
    drive_pad();
    #1;
    check_outputs();
  endtask

  initial begin
    // Reset and idle waveform
    #12;
    do_reset();
    run_scans(4);
    check("idle_buttons", buttons, 11'h000);

    // Single press of A in the low phase
    pad_lo[BTN_A] = 1'b1;
    press_seen = 0;
    run_scans(4);
    check("single_buttons", buttons, 11'h010);
    check("single_pulse_count", 11'(press_seen), 11'd1);

    // Reset asserted in the middle of S_HI_WAIT while A is debounced
    while ((cyc % P) != S + 2) step();
    #2;
    do_reset();
    run_scans(4);
    check("post_reset_buttons", buttons, 11'h010);

    // Release A
    pad_lo = '0;
    run_scans(4);
    check("release_buttons", buttons, 11'h000);

    // Bounce on C, toggled every scan
    press_seen = 0;
    for (int i = 0; i < 10; i++) begin
      pad_hi[BTN_C - LO_BITS] = i[0];
      run_scans(1);
    end
    check("bounce_pulse_count", 11'(press_seen), 11'd0);
    check("bounce_c", {10'b0, buttons[BTN_C]}, 11'h000);

    // Start (low half) and Z (high half) together
    pad_hi = '0;
    pad_lo[BTN_START] = 1'b1;
    pad_hi[BTN_Z - LO_BITS] = 1'b1;
    run_scans(4);
    check("simul_buttons", buttons, 11'h060);

    // Random button words held for a random number of scans
    for (int i = 0; i < 25; i++) begin
      pad_lo = 6'($urandom);
      pad_hi = 5'($urandom);
      run_scans(int'($urandom_range(1, 4)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
